// File: rtl/dc_pkg.sv
// Shared types for the DRAM-cache tag lookup controller.
// FSM states, packed FIFO entry layout and the request bundle.
package dc_pkg;

  localparam int DC_ADDR_W = 64;
  localparam int DC_ID_W   = 16;

  // Packed FIFO entry: {.., addr, id, rw}
  localparam int RW_BIT   = 0;
  localparam int ID_LSB   = 1;
  localparam int ADDR_LSB = DC_ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_CMP,
    S_ISSUE
  } state_e;

  typedef struct packed {
    logic                 rw;
    logic [DC_ID_W-1:0]   id;
    logic [DC_ADDR_W-1:0] addr;
  } req_t;

endpackage

// File: rtl/dc_tag_store.sv
// Direct-mapped {valid, tag} store: registered read, one write port,
// single-cycle clear of all valid bits (reset or clr_i).
module dc_tag_store #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i
);

  localparam int N = 1 << IDX_W;

  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q [N];
  logic             rd_valid_q;
  logic [TAG_W-1:0] rd_tag_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tags need no reset: a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
    end else if (rd_en_i) begin
      rd_valid_q <= valid_q[rd_idx_i];
      rd_tag_q   <= tag_q[rd_idx_i];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_tag_o   = rd_tag_q;

endmodule

// File: rtl/dc_tag_lookup_ctrl.sv
// Pops requests from the index FIFO, looks them up in the tag store and
// steers each to the hit or miss channel; supports flush and hit/miss stats.
module dc_tag_lookup_ctrl
  import dc_pkg::*;
#(
  parameter int ADDR_WIDTH      = DC_ADDR_W,
  parameter int ID_WIDTH        = DC_ID_W,
  parameter int INDEX_BIT_SIZE  = 4,
  parameter int FIFO_DATA_WIDTH = 128,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifo_empty_i,
  output logic                       fifo_rd_en_o,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_data_i,
  output logic                       hit_valid_o,
  input  logic                       hit_ready_i,
  output logic                       miss_valid_o,
  input  logic                       miss_ready_i,
  output logic                       req_rw_o,
  output logic [ID_WIDTH-1:0]        req_id_o,
  output logic [ADDR_WIDTH-1:0]      req_addr_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic [CNT_WIDTH-1:0]       hit_cnt_o,
  output logic [CNT_WIDTH-1:0]       miss_cnt_o
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_BIT_SIZE;

  state_e               state_q, state_d;
  req_t                 req_q, req_d;
  req_t                 fifo_req;
  logic                 hit_q, hit_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  logic                 st_clr;
  logic                 st_rd_en;
  logic                 st_valid;
  logic [TAG_W-1:0]     st_tag;
  logic                 st_wr_en;
  logic                 fire;
  logic                 unused_fifo;

  assign fifo_req.rw   = fifo_data_i[RW_BIT];
  assign fifo_req.id   = fifo_data_i[ID_LSB +: ID_WIDTH];
  assign fifo_req.addr = fifo_data_i[ADDR_LSB +: ADDR_WIDTH];
  assign unused_fifo   =
    ^fifo_data_i[FIFO_DATA_WIDTH-1:ADDR_LSB+ADDR_WIDTH];

  dc_tag_store #(
    .IDX_W (INDEX_BIT_SIZE),
    .TAG_W (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (st_clr),
    .rd_en_i    (st_rd_en),
    .rd_idx_i   (fifo_req.addr[INDEX_BIT_SIZE-1:0]),
    .rd_valid_o (st_valid),
    .rd_tag_o   (st_tag),
    .wr_en_i    (st_wr_en),
    .wr_idx_i   (req_q.addr[INDEX_BIT_SIZE-1:0]),
    .wr_tag_i   (req_q.addr[ADDR_WIDTH-1:INDEX_BIT_SIZE])
  );

  assign fire = hit_q ? hit_ready_i : miss_ready_i;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    hit_d        = hit_q;
    pend_d       = pend_q | flush_i;
    done_d       = 1'b0;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    fifo_rd_en_o = 1'b0;
    st_clr       = 1'b0;
    st_rd_en     = 1'b0;
    st_wr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Flush wins over a pop; a pulse arriving now re-arms it.
        if (pend_q) begin
          st_clr = 1'b1;
          pend_d = flush_i;
          done_d = 1'b1;
        end else if (!fifo_empty_i) begin
          fifo_rd_en_o = 1'b1;
          state_d      = S_POP;
        end
      end
      S_POP: begin
        req_d    = fifo_req;
        st_rd_en = 1'b1;
        state_d  = S_CMP;
      end
      S_CMP: begin
        hit_d   = st_valid &&
                  (st_tag == req_q.addr[ADDR_WIDTH-1:INDEX_BIT_SIZE]);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (fire) begin
          state_d = S_IDLE;
          if (hit_q) begin
            if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            st_wr_en = 1'b1;
            if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      hit_q      <= 1'b0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      hit_q      <= hit_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_valid_o  = (state_q == S_ISSUE) && hit_q;
  assign miss_valid_o = (state_q == S_ISSUE) && !hit_q;
  assign req_rw_o     = req_q.rw;
  assign req_id_o     = req_q.id;
  assign req_addr_o   = req_q.addr;
  assign flush_done_o = done_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule
